// File: rtl/note_judge.sv
// note_judge: judges drum presses against the three-lane note window and tracks score/combo.
module note_judge #(
    parameter int WIDTH       = 27,
    parameter int HIT_HI      = 26,
    parameter int HIT_LO      = 22,
    parameter int PERFECT_BIT = 24,
    parameter int SCORE_W     = 16,
    parameter int COMBO_W     = 10,
    parameter int PERFECT_PTS = 3,
    parameter int GOOD_PTS    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               shift_tick,
    input  logic               song_load,
    input  logic [WIDTH-1:0]   window_blue,
    input  logic [WIDTH-1:0]   window_red,
    input  logic [WIDTH-1:0]   window_yellow,
    input  logic               key_blue,
    input  logic               key_red,
    input  logic               key_yellow,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic [COMBO_W-1:0] max_combo,
    output logic               judge_valid,
    output logic [1:0]         judge_code,
    output logic [1:0]         judge_lane
);
    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
    state_t state;
    logic [2:0][WIDTH-1:0] win, cons, cons_next, avail, hm, used;
    logic [2:0] keys, key_q, press, perf, good, miss;
    logic play, clr, jv;
    logic [1:0] np, ng, nh, jc, jl;
    logic [SCORE_W-1:0] pts, score_next;
    logic [SCORE_W:0] s_sum;
    logic [COMBO_W:0] c_sum;
    logic [COMBO_W-1:0] combo_next, max_next;
    assign win   = {window_yellow, window_blue, window_red};
    assign keys  = {key_yellow, key_blue, key_red};
    assign press = keys & ~key_q;
    assign play  = state == PLAY && !song_load;
    assign clr   = state == LOAD || (state == PLAY && song_load);
    // Lane index 0/1/2 = red/blue/yellow, which is also the judge_lane encoding.
    always_comb begin
        avail = '0;
        hm = '0;
        used = '0;
        cons_next = '0;
        perf = '0;
        good = '0;
        miss = '0;
        for (int l = 0; l < 3; l++) begin
            avail[l] = win[l] & ~cons[l];
            if (play && press[l])
                for (int i = HIT_LO; i <= HIT_HI; i++)
                    if (avail[l][i]) begin
                        hm[l] = '0;
                        hm[l][i] = 1'b1;
                    end
            perf[l] = hm[l][PERFECT_BIT];
            good[l] = |hm[l] && !hm[l][PERFECT_BIT];
            used[l] = cons[l] | hm[l];
            miss[l] = play && shift_tick && win[l][WIDTH-1] && !used[l][WIDTH-1];
            cons_next[l] = shift_tick ? used[l] << 1 : used[l];
        end
    end
    always_comb begin
        np = {1'b0, perf[0]} + {1'b0, perf[1]} + {1'b0, perf[2]};
        ng = {1'b0, good[0]} + {1'b0, good[1]} + {1'b0, good[2]};
        nh = np + ng;
        pts = SCORE_W'(PERFECT_PTS) * SCORE_W'(np) + SCORE_W'(GOOD_PTS) * SCORE_W'(ng);
        s_sum = {1'b0, score} + {1'b0, pts};
        score_next = s_sum[SCORE_W] ? '1 : s_sum[SCORE_W-1:0];
        c_sum = {1'b0, combo} + (COMBO_W+1)'(nh);
        combo_next = |miss ? '0 : c_sum[COMBO_W] ? '1 : c_sum[COMBO_W-1:0];
        max_next = combo_next > max_combo ? combo_next : max_combo;
    end
    // Lowest priority written first so miss > perfect > good and red > blue > yellow win.
    always_comb begin
        jv = |miss || |perf || |good;
        jc = 2'b00;
        jl = 2'b00;
        for (int l = 2; l >= 0; l--)
            if (good[l]) begin
                jc = 2'b01;
                jl = 2'(l);
            end
        for (int l = 2; l >= 0; l--)
            if (perf[l]) begin
                jc = 2'b10;
                jl = 2'(l);
            end
        for (int l = 2; l >= 0; l--)
            if (miss[l]) begin
                jc = 2'b11;
                jl = 2'(l);
            end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            score <= '0;
            combo <= '0;
            max_combo <= '0;
            judge_valid <= 1'b0;
            judge_code <= 2'b00;
            judge_lane <= 2'b00;
            key_q <= '0;
            cons <= '0;
        end else begin
            state <= song_load ? LOAD : state == IDLE ? IDLE : PLAY;
            key_q <= keys;
            judge_valid <= play && jv;
            judge_code <= play ? jc : 2'b00;
            judge_lane <= play ? jl : 2'b00;
            if (clr) begin
                score <= '0;
                combo <= '0;
                max_combo <= '0;
                cons <= '0;
            end else if (play) begin
                score <= score_next;
                combo <= combo_next;
                max_combo <= max_next;
                cons <= cons_next;
            end
        end
    end
endmodule

// File: tb/tb_note_judge.sv
// tb_note_judge: scoreboard bench for note_judge driving directed note windows and key presses.
module tb_note_judge;
    logic clk = 1'b0, reset = 1'b1, shift_tick = 1'b0, song_load = 1'b0;
    logic [26:0] window_blue = '0, window_red = '0, window_yellow = '0;
    logic key_blue = 1'b0, key_red = 1'b0, key_yellow = 1'b0;
    logic [15:0] score;
    logic [9:0] combo, max_combo;
    logic judge_valid;
    logic [1:0] judge_code, judge_lane;
    int checks = 0, errors = 0;
    typedef struct packed {
        logic [15:0] s;
        logic [9:0] c;
        logic [9:0] m;
        logic [1:0] code;
        logic [1:0] lane;
    } exp_t;
    exp_t q[$];
    exp_t e, act;
    note_judge dut (
        .clk(clk), .reset(reset), .shift_tick(shift_tick), .song_load(song_load),
        .window_blue(window_blue), .window_red(window_red), .window_yellow(window_yellow),
        .key_blue(key_blue), .key_red(key_red), .key_yellow(key_yellow),
        .score(score), .combo(combo), .max_combo(max_combo),
        .judge_valid(judge_valid), .judge_code(judge_code), .judge_lane(judge_lane)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (judge_valid) begin
            checks++;
            act = {score, combo, max_combo, judge_code, judge_lane};
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got score=%0d combo=%0d max=%0d code=%b lane=%b, required no event",
                         score, combo, max_combo, judge_code, judge_lane);
            end else begin
                e = q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL event: got score=%0d combo=%0d max=%0d code=%b lane=%b, required score=%0d combo=%0d max=%0d code=%b lane=%b",
                             score, combo, max_combo, judge_code, judge_lane, e.s, e.c, e.m, e.code, e.lane);
                end
            end
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask
    task automatic expect_ev(input int s, input int c, input int m, input logic [1:0] code, input logic [1:0] lane);
        q.push_back({16'(s), 10'(c), 10'(m), code, lane});
    endtask
    task automatic load();
        song_load = 1'b1;
        step();
        song_load = 1'b0;
        step();
    endtask
    task automatic press(input logic [2:0] k, input logic tick);
        {key_yellow, key_blue, key_red} = k;
        shift_tick = tick;
        step();
        {key_yellow, key_blue, key_red} = 3'b000;
        shift_tick = 1'b0;
        step();
    endtask
    initial begin
        repeat (3) step();
        reset = 1'b0;
        step();
        check("reset_score", 32'(score), 0);
        check("reset_combo", 32'(combo), 0);
        check("reset_max", 32'(max_combo), 0);
        check("reset_valid", 32'(judge_valid), 0);
        check("reset_code_lane", 32'({judge_code, judge_lane}), 0);
        // red perfect
        window_red = 27'(1) << 24;
        load();
        expect_ev(3, 1, 1, 2'b10, 2'b00);
        press(3'b001, 1'b0);
        // blue good at the zone floor, then re-press on a consumed note
        window_red = '0;
        window_blue = 27'(1) << 22;
        load();
        expect_ev(1, 1, 1, 2'b01, 2'b01);
        press(3'b010, 1'b0);
        press(3'b010, 1'b0);
        step();
        check("consumed_score", 32'(score), 1);
        check("consumed_combo", 32'(combo), 1);
        // five red hits then a yellow miss
        window_blue = '0;
        window_red = 27'h1f << 22;
        load();
        expect_ev(1, 1, 1, 2'b01, 2'b00);
        expect_ev(2, 2, 2, 2'b01, 2'b00);
        expect_ev(5, 3, 3, 2'b10, 2'b00);
        expect_ev(6, 4, 4, 2'b01, 2'b00);
        expect_ev(7, 5, 5, 2'b01, 2'b00);
        repeat (5) press(3'b001, 1'b0);
        window_red = '0;
        window_yellow = 27'(1) << 26;
        expect_ev(7, 0, 5, 2'b11, 2'b10);
        press(3'b000, 1'b1);
        // press on the leaving note coincident with the tick: good, no miss
        window_yellow = '0;
        window_red = 27'(1) << 26;
        load();
        expect_ev(1, 1, 1, 2'b01, 2'b00);
        press(3'b001, 1'b1);
        // bit 21 lies below the hit zone
        window_red = 27'(1) << 21;
        press(3'b001, 1'b0);
        check("below_zone_score", 32'(score), 1);
        check("below_zone_combo", 32'(combo), 1);
        // red and blue perfect together
        window_red = 27'(1) << 24;
        window_blue = 27'(1) << 24;
        load();
        expect_ev(6, 2, 2, 2'b10, 2'b00);
        press(3'b011, 1'b0);
        // held key across two notes judges once
        window_blue = '0;
        window_red = 27'h3 << 23;
        load();
        expect_ev(3, 1, 1, 2'b10, 2'b00);
        key_red = 1'b1;
        repeat (10) step();
        key_red = 1'b0;
        step();
        check("hold_score", 32'(score), 3);
        song_load = 1'b1;
        step();
        check("reload_score", 32'(score), 0);
        check("reload_combo", 32'(combo), 0);
        check("reload_max", 32'(max_combo), 0);
        song_load = 1'b0;
        step();
        // press in the same cycle song_load rises is discarded
        song_load = 1'b1;
        key_red = 1'b1;
        step();
        song_load = 1'b0;
        key_red = 1'b0;
        step();
        step();
        check("discard_score", 32'(score), 0);
        check("discard_combo", 32'(combo), 0);
        repeat (3) step();
        check("pending_events", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/note_judge.md
Name: note_judge

Overview:
- Consumer end of the three-lane note window driven by the note shifter. Reads the 27-bit blue/red/yellow windows (bit 26 = oldest note, next to leave) and the player's drum keys.
- Judges each key press against a hit zone as perfect, good or empty, and flags unplayed notes leaving the window as misses.
- Maintains score, combo and max combo for the HUD and scoreboard.
- Sits between the note shifter, the key debouncers and the display/score logic.

Parameters:
- WIDTH, 27, window width per lane.
- HIT_HI, 26, highest window bit in the hit zone.
- HIT_LO, 22, lowest window bit in the hit zone.
- PERFECT_BIT, 24, window bit judged perfect.
- SCORE_W, 16, score width.
- COMBO_W, 10, combo and max_combo width.
- PERFECT_PTS, 3, points per perfect.
- GOOD_PTS, 1, points per good.

Ports:
- clk  in  1  system clock; the shifter's slow_clk edges arrive as shift_tick.
- reset  in  1  synchronous, active-high reset.
- shift_tick  in  1  one-clk pulse in the cycle the shifter shifts. Window inputs in that cycle are pre-shift values.
- song_load  in  1  high while a song is being loaded into the shifter.
- window_blue  in  WIDTH  blue lane window.
- window_red  in  WIDTH  red lane window.
- window_yellow  in  WIDTH  yellow lane window.
- key_blue  in  1  debounced level from the blue drum key.
- key_red  in  1  debounced level from the red drum key.
- key_yellow  in  1  debounced level from the yellow drum key.
- score  out  SCORE_W  accumulated points.
- combo  out  COMBO_W  current consecutive hits.
- max_combo  out  COMBO_W  highest combo since load.
- judge_valid  out  1  one-clk pulse when an event is judged.
- judge_code  out  2  01 good, 10 perfect, 11 miss.
- judge_lane  out  2  00 red, 01 blue, 10 yellow.

Behaviour:
- Reset:
  - State goes to IDLE.
  - score, combo, max_combo, judge_valid, judge_code and judge_lane are all 0.
  - Consumed masks and key history registers are 0.
- FSM states:
  - IDLE: ignores presses and ticks. Goes to LOAD when song_load=1.
  - LOAD: clears score, combo, max_combo and consumed masks every cycle. Goes to PLAY when song_load=0.
  - PLAY: judging is active. Goes to LOAD when song_load=1.
- Key edge detection:
  - key_q registered every cycle in all states.
  - press = key & ~key_q.
  - A held key produces exactly one press.
- Per-lane consumed mask (WIDTH bits) marks notes already judged.
  - avail = window & ~consumed.
- On a press in PLAY:
  - Select the highest-index avail bit in [HIT_HI:HIT_LO].
  - Index == PERFECT_BIT gives perfect; any other index gives good.
  - The selected bit is set in hit_mask.
  - No avail bit in the zone means an empty press: no score, no combo change, no judge pulse.
- consumed_next:
  - On shift_tick: (consumed | hit_mask) << 1, zero-filled.
  - Otherwise: consumed | hit_mask.
- Miss rule: on shift_tick in PLAY, a lane misses if window[WIDTH-1] & ~(consumed | hit_mask)[WIDTH-1].
  - A press on bit 26 in the same cycle as the tick counts as a hit, not a miss.
- All three lanes are judged in parallel in the same cycle.
  - score += PERFECT_PTS × perfects + GOOD_PTS × goods.
  - score saturates at all-ones.
- Combo:
  - If any miss occurs in a cycle, combo <= 0, even with hits in that same cycle.
  - Otherwise combo += hits, saturating at all-ones.
  - max_combo <= max(max_combo, combo_next).
- Judge report, registered, one cycle after the event:
  - Miss has priority over perfect, and perfect over good.
  - Ties are broken by lane order red, blue, yellow.
  - judge_valid=0 when there is no event.
- song_load asserted mid-PLAY takes effect on the next edge: counters and masks clear, and any event in that cycle is discarded.
- Reset mid-PLAY returns to IDLE regardless of song_load.
- Latency: outputs update on the edge after the press or tick cycle.

Test Plan:
- Reset, pulse song_load, red window bit 24=1, press key_red → score=3, combo=1, judge_valid pulse with code=10 lane=00.
- Blue note at bit 22, press → score=1, code=01. Press again with the note still in the window → no change, because the bit is consumed.
- Yellow note at bit 26 with no press, shift_tick → code=11 lane=10, combo reset from 5 to 0, score unchanged.
- Red note at bit 26, press key_red in the same cycle as shift_tick → good, no miss, combo increments.
- Red and blue both at bit 24, both keys pressed in the same cycle → score +6, combo +2, judge_lane=00.
- Hold key_red for 10 cycles across two notes → only one judged. Then assert song_load → score, combo and max_combo all read 0.
